vpu_alu_si_seq: RTL and testbench

Element sequencer for the VPU signed-integer add/sub ALU. It accepts one vector command at a time, streams element reads from up to three SRAM read ports, and drives the ALU's `en`, `sub_n`, `op_valid` and operand inputs. It buffers ALU results in a 2-entry output FIFO and writes them to the destination port under valid/ready backpressure. It sits between the VPU controller (command side), the SRAM read ports, `VPU_ALU_SI_ADD_SUB` and the VPU destination port.

---
 rtl/vpu_alu_si_seq_pkg.sv | 33 +++
 rtl/vpu_seq_res_fifo.sv | 53 +++++
 rtl/vpu_alu_si_seq.sv | 155 +++++++++++++++
 tb/tb_vpu_alu_si_seq.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_alu_si_seq_pkg.sv
// Shared types and sizing for the VPU signed-integer add/sub element sequencer.
package vpu_alu_si_seq_pkg;

  localparam int unsigned OPERAND_WIDTH   = 32;
  localparam int unsigned SRAM_R_PORT_CNT = 3;
  localparam int unsigned ADDR_WIDTH      = 10;
  localparam int unsigned LEN_WIDTH       = 10;
  localparam int unsigned SEQ_FIFO_DEPTH  = 2;
  localparam int unsigned FIFO_CNT_WIDTH  = $clog2(SEQ_FIFO_DEPTH + 1);
  localparam int unsigned FIFO_PTR_WIDTH  = $clog2(SEQ_FIFO_DEPTH);

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DRAIN,
    SEQ_DONE
  } seq_state_t;

  // Latched command; len/src_addr/dst_addr double as the live element cursors.
  typedef struct packed {
    logic                                       sub_n;
    logic                                       three_op;
    logic [LEN_WIDTH-1:0]                       len;
    logic [SRAM_R_PORT_CNT-1:0][ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0]                      dst_addr;
  } seq_cmd_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    addr;
    logic [OPERAND_WIDTH-1:0] data;
  } seq_res_t;

endpackage

// File: rtl/vpu_seq_res_fifo.sv
// Two-entry {addr, data} result FIFO; head entry drives the destination port directly.
module vpu_seq_res_fifo
  import vpu_alu_si_seq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [ADDR_WIDTH-1:0]     push_addr,
  input  logic [OPERAND_WIDTH-1:0]  push_data,
  output logic [ADDR_WIDTH-1:0]     head_addr,
  output logic [OPERAND_WIDTH-1:0]  head_data,
  output logic [FIFO_CNT_WIDTH-1:0] cnt
);

  seq_res_t                  mem [SEQ_FIFO_DEPTH];
  logic [FIFO_PTR_WIDTH-1:0] wr_ptr;
  logic [FIFO_PTR_WIDTH-1:0] rd_ptr;
  logic                      full;
  logic                      do_pop;
  logic                      do_push;

  assign full      = (cnt == FIFO_CNT_WIDTH'(SEQ_FIFO_DEPTH));
  assign do_pop    = pop && (cnt != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_addr = mem[rd_ptr].addr;
  assign head_data = mem[rd_ptr].data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SEQ_FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr].addr <= push_addr;
        mem[wr_ptr].data <= push_data;
        wr_ptr           <= wr_ptr + FIFO_PTR_WIDTH'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + FIFO_PTR_WIDTH'(1);
      if (do_push && !do_pop)      cnt <= cnt + FIFO_CNT_WIDTH'(1);
      else if (!do_push && do_pop) cnt <= cnt - FIFO_CNT_WIDTH'(1);
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
    else $error("vpu_seq_res_fifo: push into full fifo");
`endif

endmodule

// File: rtl/vpu_alu_si_seq.sv
// Element sequencer for the VPU signed add/sub ALU: streams SRAM reads, drives the ALU, writes results.
// Optional performance counters are built when VPU_SI_SEQ_PERF_EN is defined.
module vpu_alu_si_seq
  import vpu_alu_si_seq_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_sub_n,
  input  logic                       cmd_three_op,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  input  logic [ADDR_WIDTH-1:0]      cmd_src_addr [SRAM_R_PORT_CNT],
  input  logic [ADDR_WIDTH-1:0]      cmd_dst_addr,
  output logic [SRAM_R_PORT_CNT-1:0] rd_en,
  output logic [ADDR_WIDTH-1:0]      rd_addr [SRAM_R_PORT_CNT],
  input  logic [OPERAND_WIDTH-1:0]   rd_data [SRAM_R_PORT_CNT],
  output logic                       alu_en,
  output logic                       alu_sub_n,
  output logic [SRAM_R_PORT_CNT-1:0] alu_op_valid,
  output logic [OPERAND_WIDTH-1:0]   alu_op_0,
  output logic [OPERAND_WIDTH-1:0]   alu_op_1,
  output logic [OPERAND_WIDTH-1:0]   alu_op_2,
  input  logic [OPERAND_WIDTH-1:0]   alu_result,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic [OPERAND_WIDTH-1:0]   wr_data,
  output logic                       busy,
`ifdef VPU_SI_SEQ_PERF_EN
  output logic [31:0]                perf_busy_cycles,
  output logic [31:0]                perf_stall_cycles,
`endif
  output logic                       done
);

  localparam int unsigned CREDIT_WIDTH = FIFO_CNT_WIDTH + 1;

  seq_state_t                state;
  seq_state_t                state_nxt;
  seq_cmd_t                  cmd_q;
  logic                      inflight;
  logic [FIFO_CNT_WIDTH-1:0] fifo_cnt;
  logic                      accept;
  logic                      issue;
  logic                      credit_ok;
  logic                      pop;

  assign pop      = wr_valid && wr_ready;
  assign wr_valid = (fifo_cnt != '0);
  assign busy     = (state != SEQ_IDLE);
  assign accept   = cmd_valid && cmd_ready;
  // Slots already owed (queued + returning) must leave room for one more element.
  assign credit_ok = (CREDIT_WIDTH'(fifo_cnt) + CREDIT_WIDTH'(inflight))
                   < (CREDIT_WIDTH'(SEQ_FIFO_DEPTH) + CREDIT_WIDTH'(pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEQ_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    unique case (state)
      SEQ_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) state_nxt = (cmd_len == '0) ? SEQ_DONE : SEQ_RUN;
      end
      SEQ_RUN: begin
        issue = credit_ok && (cmd_q.len != '0);
        if ((cmd_q.len == '0) || (issue && (cmd_q.len == LEN_WIDTH'(1)))) state_nxt = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        if (!inflight && ((fifo_cnt == '0) || ((fifo_cnt == FIFO_CNT_WIDTH'(1)) && pop)))
          state_nxt = SEQ_DONE;
      end
      SEQ_DONE: begin
        done      = 1'b1;
        state_nxt = SEQ_IDLE;
      end
      default: state_nxt = SEQ_IDLE;
    endcase
  end

  // Command latch and per-element cursors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept) begin
        cmd_q.sub_n    <= cmd_sub_n;
        cmd_q.three_op <= cmd_three_op;
        cmd_q.len      <= cmd_len;
        cmd_q.dst_addr <= cmd_dst_addr;
        for (int p = 0; p < int'(SRAM_R_PORT_CNT); p++) cmd_q.src_addr[p] <= cmd_src_addr[p];
      end else begin
        if (issue) begin
          cmd_q.len <= cmd_q.len - LEN_WIDTH'(1);
          for (int p = 0; p < int'(SRAM_R_PORT_CNT); p++)
            cmd_q.src_addr[p] <= cmd_q.src_addr[p] + ADDR_WIDTH'(1);
        end
        if (inflight) cmd_q.dst_addr <= cmd_q.dst_addr + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    for (int p = 0; p < int'(SRAM_R_PORT_CNT); p++) begin
      rd_en[p]   = issue && ((p < 2) || cmd_q.three_op);
      rd_addr[p] = (issue && ((p < 2) || cmd_q.three_op)) ? cmd_q.src_addr[p] : '0;
    end
  end

  // ALU is driven only in the cycle read data returns.
  assign alu_en       = inflight;
  assign alu_sub_n    = inflight && cmd_q.sub_n;
  assign alu_op_valid = inflight ? {cmd_q.three_op, 1'b1, 1'b1} : '0;
  assign alu_op_0     = inflight ? rd_data[0] : '0;
  assign alu_op_1     = inflight ? rd_data[1] : '0;
  assign alu_op_2     = inflight ? rd_data[2] : '0;

  vpu_seq_res_fifo u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .pop       (pop),
    .push_addr (cmd_q.dst_addr),
    .push_data (alu_result),
    .head_addr (wr_addr),
    .head_data (wr_data),
    .cnt       (fifo_cnt)
  );

`ifdef VPU_SI_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (accept) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && (perf_busy_cycles != '1)) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if ((state == SEQ_RUN) && (cmd_q.len != '0) && !issue && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vpu_alu_si_seq.sv
// Directed self-checking bench for vpu_alu_si_seq with an SRAM model and an add/sub ALU model.
module tb_vpu_alu_si_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_sub_n = 1'b0;
  logic        cmd_three_op = 1'b0;
  logic [9:0]  cmd_len = '0;
  logic [9:0]  cmd_src_addr [3];
  logic [9:0]  cmd_dst_addr = '0;
  logic [2:0]  rd_en;
  logic [9:0]  rd_addr [3];
  logic [31:0] rd_data [3];
  logic        alu_en;
  logic        alu_sub_n;
  logic [2:0]  alu_op_valid;
  logic [31:0] alu_op_0, alu_op_1, alu_op_2;
  logic [31:0] alu_result;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
`ifdef VPU_SI_SEQ_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [31:0] perf_stall_cycles;
`endif

  logic [31:0] sram [3][1024];
  int          cyc = 0;
  int          cyc0 = 0;
  int          checks = 0;
  int          passed = 0;
  int          stab_err = 0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [9:0]  pa = '0;
  logic [31:0] pd = '0;

  int          wr_cyc_q[$];
  logic [9:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rd_cyc_q[$];
  logic [2:0]  rd_mask_q[$];
  logic [9:0]  rd_addr0_q[$];
  logic [2:0]  alu_valid_q[$];
  logic        alu_sub_q[$];

  vpu_alu_si_seq dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_sub_n    (cmd_sub_n),
    .cmd_three_op (cmd_three_op),
    .cmd_len      (cmd_len),
    .cmd_src_addr (cmd_src_addr),
    .cmd_dst_addr (cmd_dst_addr),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .alu_en       (alu_en),
    .alu_sub_n    (alu_sub_n),
    .alu_op_valid (alu_op_valid),
    .alu_op_0     (alu_op_0),
    .alu_op_1     (alu_op_1),
    .alu_op_2     (alu_op_2),
    .alu_result   (alu_result),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
`ifdef VPU_SI_SEQ_PERF_EN
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: one-cycle read latency per port.
  always @(posedge clk) begin
    for (int p = 0; p < 3; p++)
      if (rd_en[p]) rd_data[p] <= sram[p][rd_addr[p]];
  end

  // External add/sub ALU model.
  always_comb begin
    logic [31:0] op2m;
    op2m       = alu_op_valid[2] ? alu_op_2 : 32'd0;
    alu_result = 32'd0;
    if (alu_en) alu_result = alu_sub_n ? (alu_op_0 + alu_op_1 + op2m) : (alu_op_0 - alu_op_1 - op2m);
  end

  // Mid-cycle event logger.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid && wr_ready) begin
        wr_cyc_q.push_back(cyc); wr_addr_q.push_back(wr_addr); wr_data_q.push_back(wr_data);
      end
      if (rd_en != 3'b000) begin
        rd_cyc_q.push_back(cyc); rd_mask_q.push_back(rd_en); rd_addr0_q.push_back(rd_addr[0]);
      end
      if (alu_en) begin
        alu_valid_q.push_back(alu_op_valid); alu_sub_q.push_back(alu_sub_n);
      end
      if (pv && !pr && (wr_valid !== 1'b1 || wr_addr !== pa || wr_data !== pd)) stab_err <= stab_err + 1;
    end
    pv <= rst ? 1'b0 : wr_valid;
    pr <= wr_ready;
    pa <= wr_addr;
    pd <= wr_data;
  end

  task automatic clear_logs();
    wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    rd_cyc_q.delete(); rd_mask_q.delete(); rd_addr0_q.delete();
    alu_valid_q.delete(); alu_sub_q.delete();
  endtask

  task automatic send_cmd(input logic sub_n, input logic three, input int len,
                          input int s0, input int s1, input int s2, input int d);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_sub_n = sub_n; cmd_three_op = three; cmd_len = 10'(len);
    cmd_src_addr[0] = 10'(s0); cmd_src_addr[1] = 10'(s1); cmd_src_addr[2] = 10'(s2);
    cmd_dst_addr = 10'(d);
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
    end
    cyc0 = cyc;
    checks++;
    if (!ok) $display("FAIL cmd_handshake: cmd_ready=%b, required 1 within 20 cycles", cmd_ready);
    else passed++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin dcyc = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rd_en, alu_en, alu_sub_n, alu_op_valid, wr_valid, busy, done} !== 11'd0)
      $display("FAIL reset_ctrl: got %b, required all 0", {cmd_ready, rd_en, alu_en, alu_sub_n, alu_op_valid, wr_valid, busy, done});
    else passed++;
    checks++;
    if ({wr_addr, wr_data, alu_op_0} !== 74'd0) $display("FAIL reset_data: wr_addr=%h wr_data=%h op0=%h, required 0", wr_addr, wr_data, alu_op_0);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else passed++;
  endtask

  task automatic test_add_len4();
    int dcyc;
    clear_logs();
    wr_ready = 1'b1;
    send_cmd(1'b1, 1'b0, 4, 'h010, 'h020, 0, 'h030);
    wait_done(40, dcyc);
    checks++;
    if (dcyc != cyc0 + 7) $display("FAIL add4_done_cycle: got %0d, required %0d", dcyc - cyc0, 7); else passed++;
    checks++;
    if (cmd_ready !== 1'b0) $display("FAIL add4_ready_in_done: got %b, required 0", cmd_ready); else passed++;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL add4_ready_after: got %b, required 1", cmd_ready); else passed++;
    checks++;
    if (wr_data_q.size() != 4) $display("FAIL add4_write_count: got %0d, required 4", wr_data_q.size()); else passed++;
    checks++;
    if (rd_cyc_q.size() != 4 || rd_cyc_q[0] != cyc0 + 1)
      $display("FAIL add4_reads: count %0d first cycle %0d, required 4 at 1", rd_cyc_q.size(), rd_cyc_q[0] - cyc0);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_data_q[i] !== 32'(11 * (i + 1))) $display("FAIL add4_data[%0d]: got %0d, required %0d", i, wr_data_q[i], 11 * (i + 1));
      else passed++;
      checks++;
      if (wr_addr_q[i] !== 10'('h030 + i)) $display("FAIL add4_addr[%0d]: got %h, required %h", i, wr_addr_q[i], 'h030 + i);
      else passed++;
      checks++;
      if (wr_cyc_q[i] != cyc0 + 3 + i) $display("FAIL add4_wr_cycle[%0d]: got %0d, required %0d", i, wr_cyc_q[i] - cyc0, 3 + i);
      else passed++;
      checks++;
      if (rd_mask_q[i] !== 3'b011) $display("FAIL add4_rd_mask[%0d]: got %b, required 011", i, rd_mask_q[i]); else passed++;
    end
`ifdef VPU_SI_SEQ_PERF_EN
    checks++;
    if (perf_busy_cycles !== 32'd7) $display("FAIL add4_perf_busy: got %0d, required 7", perf_busy_cycles); else passed++;
    checks++;
    if (perf_stall_cycles !== 32'd0) $display("FAIL add4_perf_stall: got %0d, required 0", perf_stall_cycles); else passed++;
`endif
  endtask

  task automatic test_sub_three_op();
    int dcyc;
    clear_logs();
    send_cmd(1'b0, 1'b1, 1, 'h040, 'h050, 'h060, 'h070);
    wait_done(40, dcyc);
    @(negedge clk);
    checks++;
    if (dcyc != cyc0 + 4) $display("FAIL sub3_done_cycle: got %0d, required 4", dcyc - cyc0); else passed++;
    checks++;
    if (alu_valid_q.size() != 1 || alu_valid_q[0] !== 3'b111)
      $display("FAIL sub3_op_valid: got %b (n=%0d), required 111", alu_valid_q[0], alu_valid_q.size());
    else passed++;
    checks++;
    if (alu_sub_q[0] !== 1'b0) $display("FAIL sub3_sub_n: got %b, required 0", alu_sub_q[0]); else passed++;
    checks++;
    if (rd_mask_q[0] !== 3'b111) $display("FAIL sub3_rd_mask: got %b, required 111", rd_mask_q[0]); else passed++;
    checks++;
    if (wr_data_q[0] !== 32'd65 || wr_addr_q[0] !== 10'h070)
      $display("FAIL sub3_write: got %0d@%h, required 65@070", wr_data_q[0], wr_addr_q[0]);
    else passed++;
  endtask

  task automatic test_backpressure();
    int dcyc;
    int early;
    clear_logs();
    wr_ready = 1'b0;
    send_cmd(1'b1, 1'b0, 3, 'h080, 'h090, 0, 'h0A0);
    repeat (8) @(posedge clk);
    #1 wr_ready = 1'b1;
    wait_done(40, dcyc);
    @(negedge clk);
    early = 0;
    foreach (rd_cyc_q[i]) if (rd_cyc_q[i] <= cyc0 + 8) early++;
    checks++;
    if (early != 2) $display("FAIL bp_reads_before_release: got %0d, required 2", early); else passed++;
    checks++;
    if (wr_cyc_q.size() != 3 || wr_cyc_q[0] != cyc0 + 9)
      $display("FAIL bp_first_write: count %0d cycle %0d, required 3 at 9", wr_cyc_q.size(), wr_cyc_q[0] - cyc0);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr_q[i] !== 10'('h0A0 + i) || wr_data_q[i] !== 32'(6 + i))
        $display("FAIL bp_order[%0d]: got %0d@%h, required %0d@%h", i, wr_data_q[i], wr_addr_q[i], 6 + i, 'h0A0 + i);
      else passed++;
    end
    checks++;
    if (stab_err != 0) $display("FAIL bp_wr_stable: got %0d changes while stalled, required 0", stab_err); else passed++;
    checks++;
    if (dcyc != cyc0 + 12) $display("FAIL bp_done_cycle: got %0d, required 12", dcyc - cyc0); else passed++;
`ifdef VPU_SI_SEQ_PERF_EN
    checks++;
    if (perf_stall_cycles !== 32'd6) $display("FAIL bp_perf_stall: got %0d, required 6", perf_stall_cycles); else passed++;
    checks++;
    if (perf_busy_cycles !== 32'd12) $display("FAIL bp_perf_busy: got %0d, required 12", perf_busy_cycles); else passed++;
`endif
  endtask

  task automatic test_wrap();
    int dcyc;
    clear_logs();
    send_cmd(1'b1, 1'b0, 2, 'h3FF, 'h3FF, 0, 'h3FF);
    wait_done(40, dcyc);
    @(negedge clk);
    checks++;
    if (rd_addr0_q.size() != 2 || rd_addr0_q[0] !== 10'h3FF || rd_addr0_q[1] !== 10'h000)
      $display("FAIL wrap_rd_addr: got %h,%h, required 3ff,000", rd_addr0_q[0], rd_addr0_q[1]);
    else passed++;
    checks++;
    if (wr_data_q[0] !== 32'h8000_0000) $display("FAIL wrap_overflow_add: got %h, required 80000000", wr_data_q[0]); else passed++;
    checks++;
    if (wr_data_q[1] !== 32'h0000_0001) $display("FAIL wrap_modulo_add: got %h, required 00000001", wr_data_q[1]); else passed++;
    checks++;
    if (wr_addr_q[0] !== 10'h3FF || wr_addr_q[1] !== 10'h000)
      $display("FAIL wrap_wr_addr: got %h,%h, required 3ff,000", wr_addr_q[0], wr_addr_q[1]);
    else passed++;
  endtask

  task automatic test_reset_mid_cmd();
    int dcyc;
    clear_logs();
    send_cmd(1'b1, 1'b0, 8, 'h010, 'h020, 0, 'h200);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({rd_en, alu_en, alu_op_valid, wr_valid, busy, done, cmd_ready} !== 10'd0 || alu_op_0 !== 32'd0)
      $display("FAIL midrst_outputs: ctrl %b op0 %h, required 0", {rd_en, alu_en, alu_op_valid, wr_valid, busy, done, cmd_ready}, alu_op_0);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || wr_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL midrst_release: ready %b wr_valid %b busy %b, required 1 0 0", cmd_ready, wr_valid, busy);
    else passed++;
    send_cmd(1'b1, 1'b0, 2, 'h010, 'h020, 0, 'h100);
    wait_done(40, dcyc);
    @(negedge clk);
    checks++;
    if (wr_data_q.size() != 2) $display("FAIL midrst_write_count: got %0d, required 2", wr_data_q.size()); else passed++;
    checks++;
    if (wr_data_q[0] !== 32'd11 || wr_data_q[1] !== 32'd22 || wr_addr_q[0] !== 10'h100 || wr_addr_q[1] !== 10'h101)
      $display("FAIL midrst_next_cmd: got %0d@%h %0d@%h, required 11@100 22@101", wr_data_q[0], wr_addr_q[0], wr_data_q[1], wr_addr_q[1]);
    else passed++;
    checks++;
    if (dcyc != cyc0 + 5) $display("FAIL midrst_done_cycle: got %0d, required 5", dcyc - cyc0); else passed++;
  endtask

  task automatic test_len_zero();
    int dcyc;
    clear_logs();
    send_cmd(1'b1, 1'b1, 0, 'h010, 'h020, 'h030, 'h040);
    wait_done(10, dcyc);
    checks++;
    if (dcyc != cyc0 + 1) $display("FAIL len0_done_cycle: got %0d, required 1", dcyc - cyc0); else passed++;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL len0_ready: got %b, required 1", cmd_ready); else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (rd_cyc_q.size() != 0 || wr_cyc_q.size() != 0)
      $display("FAIL len0_no_traffic: reads %0d writes %0d, required 0 0", rd_cyc_q.size(), wr_cyc_q.size());
    else passed++;
`ifdef VPU_SI_SEQ_PERF_EN
    checks++;
    if (perf_busy_cycles !== 32'd1) $display("FAIL len0_perf_busy: got %0d, required 1", perf_busy_cycles); else passed++;
`endif
  endtask

  initial begin
    for (int p = 0; p < 3; p++) begin
      cmd_src_addr[p] = '0;
      rd_data[p] = '0;
      for (int a = 0; a < 1024; a++) sram[p][a] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      sram[0]['h010 + i] = 32'(i + 1);
      sram[1]['h020 + i] = 32'(10 * (i + 1));
    end
    sram[0]['h040] = 32'd100; sram[1]['h050] = 32'd30; sram[2]['h060] = 32'd5;
    for (int i = 0; i < 3; i++) begin
      sram[0]['h080 + i] = 32'(5 + i);
      sram[1]['h090 + i] = 32'd1;
    end
    sram[0]['h3FF] = 32'h7FFF_FFFF; sram[1]['h3FF] = 32'd1;
    sram[0]['h000] = 32'hFFFF_FFFF; sram[1]['h000] = 32'd2;

    test_reset();
    test_add_len4();
    test_sub_three_op();
    test_backpressure();
    test_wrap();
    test_reset_mid_cmd();
    test_len_zero();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
